sdp_cmpsel_pipe: RTL and testbench

- Parametrised, pipelined successor to the single-cycle signed compare/select/shift datapath. Per transaction it computes:
  - d = a+b, e = a+c, f = a-b
  - g = (d<e) ? d : e
  - h = (d==e) ? g : f
  - x = g << (d<e ? SHAMT : 0)
  - z = h >> (d==e ? SHAMT : 0)
- Adds a 3-stage pipeline, valid/ready handshake on both sides with full backpressure, configurable width and shift amount, and a per-transaction arithmetic/logical right-shift mode.
- Sits between an upstream producer and a downstream consumer in the scheduled-datapath test circuits.

---
 rtl/sdp_cmpsel_pipe.sv | 134 +++++++++++++
 tb/tb_sdp_cmpsel_pipe.sv | 132 +++++++++++++
 2 files changed

// File: rtl/sdp_cmpsel_pipe.sv
// Three-stage signed add/compare/select/shift datapath; results leave 3 cycles after acceptance.
// Valid/ready on both sides; a stalled output freezes S3 and the upstream stages fill behind it.
module sdp_cmpsel_pipe #(
  parameter int DATAWIDTH = 32,
  parameter int SHAMT     = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  input  logic [DATAWIDTH-1:0] c,
  input  logic                 sra,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [DATAWIDTH-1:0] x,
  output logic [DATAWIDTH-1:0] z,
  output logic                 out_valid,
  input  logic                 out_ready
);
  localparam int W = DATAWIDTH;

  logic [W-1:0] d_q, d_d, e_q, e_d, f_q, f_d;
  logic         sra1_q, sra1_d, v1_q, v1_d;
  logic [W-1:0] g_q, g_d, h_q, h_d;
  logic         lt_q, lt_d, eq_q, eq_d, sra2_q, sra2_d, v2_q, v2_d;
  logic [W-1:0] x_q, x_d, z_q, z_d;
  logic         v3_q, v3_d;

  logic         adv1, adv2, adv3;
  logic         lt_c, eq_c;
  logic [W-1:0] g_c, h_c;
  logic signed [W-1:0] h_s;

  always_comb begin
    adv3 = !v3_q || out_ready;
    adv2 = !v2_q || adv3;
    adv1 = !v1_q || adv2;
  end

  assign in_ready = adv1;

  // Stage 1: sums and difference, wrapping modulo 2^W.
  always_comb begin
    d_d    = d_q;
    e_d    = e_q;
    f_d    = f_q;
    sra1_d = sra1_q;
    v1_d   = adv1 ? in_valid : v1_q;
    if (adv1 && in_valid) begin
      d_d    = a + b;
      e_d    = a + c;
      f_d    = a - b;
      sra1_d = sra;
    end
  end

  // Stage 2: signed compare and select.
  always_comb begin
    lt_c   = $signed(d_q) < $signed(e_q);
    eq_c   = (d_q == e_q);
    g_c    = lt_c ? d_q : e_q;
    h_c    = eq_c ? g_c : f_q;
    g_d    = g_q;
    h_d    = h_q;
    lt_d   = lt_q;
    eq_d   = eq_q;
    sra2_d = sra2_q;
    v2_d   = adv2 ? v1_q : v2_q;
    if (adv2 && v1_q) begin
      g_d    = g_c;
      h_d    = h_c;
      lt_d   = lt_c;
      eq_d   = eq_c;
      sra2_d = sra1_q;
    end
  end

  // Stage 3: flag-gated shifts; h_s keeps the arithmetic shift self-contained.
  always_comb begin
    h_s  = h_q;
    x_d  = x_q;
    z_d  = z_q;
    v3_d = adv3 ? v2_q : v3_q;
    if (adv3 && v2_q) begin
      x_d = lt_q ? (g_q << SHAMT) : g_q;
      if (!eq_q) begin
        z_d = h_q;
      end else if (sra2_q) begin
        z_d = h_s >>> SHAMT;
      end else begin
        z_d = h_q >> SHAMT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_q    <= '0;
      e_q    <= '0;
      f_q    <= '0;
      sra1_q <= 1'b0;
      v1_q   <= 1'b0;
      g_q    <= '0;
      h_q    <= '0;
      lt_q   <= 1'b0;
      eq_q   <= 1'b0;
      sra2_q <= 1'b0;
      v2_q   <= 1'b0;
      x_q    <= '0;
      z_q    <= '0;
      v3_q   <= 1'b0;
    end else begin
      d_q    <= d_d;
      e_q    <= e_d;
      f_q    <= f_d;
      sra1_q <= sra1_d;
      v1_q   <= v1_d;
      g_q    <= g_d;
      h_q    <= h_d;
      lt_q   <= lt_d;
      eq_q   <= eq_d;
      sra2_q <= sra2_d;
      v2_q   <= v2_d;
      x_q    <= x_d;
      z_q    <= z_d;
      v3_q   <= v3_d;
    end
  end

  assign x         = x_q;
  assign z         = z_q;
  assign out_valid = v3_q;

endmodule

// File: tb/tb_sdp_cmpsel_pipe.sv
// Directed bench for sdp_cmpsel_pipe with DATAWIDTH=32, SHAMT=1; expected results are hand-derived.
module tb_sdp_cmpsel_pipe;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] a = '0, b = '0, c = '0;
  logic        sra = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] x, z;
  logic        out_valid;
  logic        out_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [31:0] va[6], vb[6], vc[6], ex[6], ez[6];
  logic        vs[6];

  sdp_cmpsel_pipe #(.DATAWIDTH(32), .SHAMT(1)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .sra(sra),
    .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .z(z), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Streams vectors first..first+n-1; entered and left at 1 time unit after a rising edge.
  task automatic run(input int first, input int n, input bit stall);
    int send = 0, recv = 0, cyc = 0, stall_cnt = 0;
    int acc_cyc[6];
    logic [31:0] hx = '0, hz = '0;
    while (recv < n && cyc < 60) begin
      in_valid = (send < n);
      if (send < n) begin
        a   = va[first+send];
        b   = vb[first+send];
        c   = vc[first+send];
        sra = vs[first+send];
      end
      out_ready = !(stall && stall_cnt < 5);
      #4;
      if (stall && out_valid && !out_ready) begin
        if (stall_cnt == 0) begin
          hx = x;
          hz = z;
        end else begin
          chk("hold_x", x, hx);
          chk("hold_z", z, hz);
        end
        stall_cnt++;
      end
      chk("in_ready", {31'b0, in_ready}, (send - recv == 3 && !out_ready) ? 32'd0 : 32'd1);
      if (out_valid && out_ready) begin
        chk("x", x, ex[first+recv]);
        chk("z", z, ez[first+recv]);
        if (!stall) chk("latency", cyc - acc_cyc[recv], 32'd3);
        recv++;
      end
      if (in_valid && in_ready) begin
        acc_cyc[send] = cyc;
        send++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("delivered", recv, n);
    if (stall) chk("stall_cycles", stall_cnt, 32'd5);
    in_valid = 1'b0;
  endtask

  initial begin
    // no-shift / lt path / eq with sra=1 / eq with sra=0 / wrap / eq with logical shift of positive
    va[0] = 32'd5;          vb[0] = 32'd3; vc[0] = 32'd1; vs[0] = 1'b1; ex[0] = 32'd6;          ez[0] = 32'd2;
    va[1] = 32'd2;          vb[1] = 32'd1; vc[1] = 32'd4; vs[1] = 1'b1; ex[1] = 32'd6;          ez[1] = 32'd1;
    va[2] = 32'hFFFFFFFC;   vb[2] = 32'd2; vc[2] = 32'd2; vs[2] = 1'b1; ex[2] = 32'hFFFFFFFE;   ez[2] = 32'hFFFFFFFF;
    va[3] = 32'hFFFFFFFC;   vb[3] = 32'd2; vc[3] = 32'd2; vs[3] = 1'b0; ex[3] = 32'hFFFFFFFE;   ez[3] = 32'h7FFFFFFF;
    va[4] = 32'h7FFFFFFF;   vb[4] = 32'd1; vc[4] = 32'd0; vs[4] = 1'b1; ex[4] = 32'h00000000;   ez[4] = 32'h7FFFFFFE;
    va[5] = 32'd10;         vb[5] = 32'd3; vc[5] = 32'd3; vs[5] = 1'b0; ex[5] = 32'd13;         ez[5] = 32'd6;

    #1;
    chk("rst_x", x, 32'd0);
    chk("rst_z", z, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #1;

    run(0, 2, 1'b0);
    run(2, 4, 1'b0);
    run(0, 6, 1'b1);

    // Fill the pipe with out_ready low, then reset between edges.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = va[i]; b = vb[i]; c = vc[i]; sra = vs[i];
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    #2;
    chk("pre_rst_out_valid", {31'b0, out_valid}, 32'd1);
    chk("pre_rst_in_ready", {31'b0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_x", x, 32'd0);
    chk("arst_z", z, 32'd0);
    chk("arst_in_ready", {31'b0, in_ready}, 32'd1);
    #2 rst = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #4;
      chk("no_stale", {31'b0, out_valid}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
